// File: rtl/iobus_pkg.sv
// Shared definitions for IO bus responders: register offsets, CTRL/STATUS
// bit positions and packed register layouts.
package iobus_pkg;

    // Timer register offsets relative to the responder base address
    localparam logic [31:0] TMR_CTRL_OFS     = 32'h00;
    localparam logic [31:0] TMR_LOAD_OFS     = 32'h04;
    localparam logic [31:0] TMR_COUNT_OFS    = 32'h08;
    localparam logic [31:0] TMR_STATUS_OFS   = 32'h0C;
    localparam logic [31:0] TMR_PRESCALE_OFS = 32'h10;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;

    // STATUS register bit positions
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;

    // CTRL layout: {IE, AUTO, EN}, EN in the LSB
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } tmr_ctrl_t;

    // STATUS layout: {OVR, PEND}, PEND in the LSB
    typedef struct packed {
        logic ovr;
        logic pend;
    } tmr_status_t;

endpackage

// File: rtl/iobus_timer_presc.sv
// Prescaler / tick generator for iobus_timer. Only instantiated when
// IOBUS_TIMER_PRESCALE_EN is defined. Emits one tick every PRESCALE+1
// enabled cycles; the counter restarts on a PRESCALE write or timer start.
module iobus_timer_presc (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic        wr,
    input  logic [15:0] wdata,
    output logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] ps;

    assign tick = en & (ps == prescale);

    // PRESCALE register and the free-running divider that wraps at PRESCALE
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            ps       <= '0;
        end else begin
            if (wr) begin
                prescale <= wdata;
            end
            if (wr || clear) begin
                ps <= '0;
            end else if (en) begin
                ps <= tick ? 16'h0000 : ps + 16'h0001;
            end
        end
    end

endmodule

// File: rtl/iobus_timer.sv
// Memory-mapped down-counting timer on the MCU IO bus responder side.
// Registers: CTRL, LOAD, COUNT (read-only), STATUS (write-1-to-clear) and,
// when IOBUS_TIMER_PRESCALE_EN is defined, a 16-bit PRESCALE register.
// INTR is a level request built purely from flops (PEND & IE).
module iobus_timer
    import iobus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0300,
    parameter int          CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    // Word addresses of each register; the byte offset bits are ignored
    localparam logic [29:0] CTRL_WA   = 30'((BASE_ADDR + TMR_CTRL_OFS)   >> 2);
    localparam logic [29:0] LOAD_WA   = 30'((BASE_ADDR + TMR_LOAD_OFS)   >> 2);
    localparam logic [29:0] COUNT_WA  = 30'((BASE_ADDR + TMR_COUNT_OFS)  >> 2);
    localparam logic [29:0] STATUS_WA = 30'((BASE_ADDR + TMR_STATUS_OFS) >> 2);

    tmr_ctrl_t        ctrl;
    tmr_status_t      status;
    tmr_status_t      status_next;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             tick;
    logic             expire;
    logic             sel_ctrl, sel_load, sel_count, sel_status;
    logic             wr_ctrl, wr_load, wr_status;
    logic             unused_bits;

    assign sel_ctrl   = (IOBUS_ADDR[31:2] == CTRL_WA);
    assign sel_load   = (IOBUS_ADDR[31:2] == LOAD_WA);
    assign sel_count  = (IOBUS_ADDR[31:2] == COUNT_WA);
    assign sel_status = (IOBUS_ADDR[31:2] == STATUS_WA);

    assign wr_ctrl   = IOBUS_WR & sel_ctrl;
    assign wr_load   = IOBUS_WR & sel_load;
    assign wr_status = IOBUS_WR & sel_status;

    assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

`ifdef IOBUS_TIMER_PRESCALE_EN
    localparam logic [29:0] PRESCALE_WA = 30'((BASE_ADDR + TMR_PRESCALE_OFS) >> 2);

    logic        sel_prescale;
    logic        wr_prescale;
    logic        en_start;
    logic [15:0] prescale;

    assign sel_prescale = (IOBUS_ADDR[31:2] == PRESCALE_WA);
    assign wr_prescale  = IOBUS_WR & sel_prescale;
    assign en_start     = wr_ctrl & IOBUS_OUT[CTRL_EN_BIT] & ~ctrl.en;

    iobus_timer_presc u_presc (
        .clk      (CLK),
        .rst      (RST),
        .en       (ctrl.en),
        .clear    (en_start),
        .wr       (wr_prescale),
        .wdata    (IOBUS_OUT[15:0]),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = ctrl.en;
`endif

    assign expire = tick & (count == '0);
    assign INTR   = status.pend & ctrl.ie;

    // Next COUNT and STATUS: LOAD writes override counting; a new expiry beats a W1C
    always_comb begin
        count_next = count;
        if (wr_load) begin
            count_next = IOBUS_OUT[CNT_W-1:0];
        end else if (tick) begin
            if (count != '0) begin
                count_next = count - CNT_W'(1);
            end else if (ctrl.auto_rl) begin
                count_next = load;
            end
        end
        status_next.pend = (status.pend & ~(wr_status & IOBUS_OUT[STAT_PEND_BIT])) | expire;
        status_next.ovr  = (status.ovr  & ~(wr_status & IOBUS_OUT[STAT_OVR_BIT]))
                         | (expire & status.pend);
    end

    // Register file update; a one-shot expiry drops EN unless CTRL is written
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl   <= '0;
            load   <= '0;
            count  <= '0;
            status <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= tmr_ctrl_t'(IOBUS_OUT[2:0]);
            end else if (expire && !ctrl.auto_rl) begin
                ctrl.en <= 1'b0;
            end
            if (wr_load) begin
                load <= IOBUS_OUT[CNT_W-1:0];
            end
            count  <= count_next;
            status <= status_next;
        end
    end

    // Combinational read mux; zero whenever the address misses the window
    always_comb begin
        IOBUS_IN = '0;
        if (sel_ctrl) begin
            IOBUS_IN[2:0] = ctrl;
        end else if (sel_load) begin
            IOBUS_IN[CNT_W-1:0] = load;
        end else if (sel_count) begin
            IOBUS_IN[CNT_W-1:0] = count;
        end else if (sel_status) begin
            IOBUS_IN[1:0] = status;
        end
`ifdef IOBUS_TIMER_PRESCALE_EN
        else if (sel_prescale) begin
            IOBUS_IN[15:0] = prescale;
        end
`endif
    end

endmodule

// File: doc/iobus_timer.md
Name: iobus_timer

Overview:
Memory-mapped down-counting timer. It sits on the responder side of the MCU IO bus: it decodes IO writes, returns read data for IO loads, and drives the MCU INTR input. It is the first IO peripheral able to raise interrupts into the pipeline's CSR/MTVEC path. One instance per timer; the top level muxes IOBUS_IN when several responders are present.

Parameters:
BASE_ADDR, 32'h1100_0300, word-aligned base address of the register window
CNT_W, 32, width of LOAD/COUNT (1..32); upper bits read as 0

Ports:
CLK  in  1  system clock, same as MCU
RST  in  1  synchronous active-high reset
IOBUS_ADDR  in  32  MCU IO address (MEM-stage ALU result)
IOBUS_OUT  in  32  MCU write data
IOBUS_WR  in  1  MCU IO write strobe, one cycle per store
IOBUS_IN  out  32  read data to MCU
INTR  out  1  level interrupt request to MCU

Behaviour:
- Register map; offsets from BASE_ADDR; IOBUS_ADDR[1:0] ignored; all other bits must match.
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable).
  - 0x04 LOAD, RW.
  - 0x08 COUNT, RO; writes ignored.
  - 0x0C STATUS: bit0 PEND, bit1 OVR. Write-1-to-clear per bit.
  - 0x10 PRESCALE: only with the macro; otherwise reads 0 and writes are ignored.
- Writes take effect at the CLK edge where IOBUS_WR=1 and the address hits. Non-hitting addresses: no effect.
- Reads are combinational: IOBUS_IN = selected register while IOBUS_ADDR hits, else 32'h0. Independent of IOBUS_WR. Zero latency, so data is valid in the same cycle the MCU presents the address.
- Tick: 1 every cycle (no prescaler).
- On a tick with EN=1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0 (expiry): PEND sets. If PEND was already 1, OVR also sets.
  - After expiry with AUTO=1: COUNT <= LOAD.
  - After expiry with AUTO=0: EN clears and COUNT stays 0.
- Writing LOAD also copies the value into COUNT on the same edge. This overrides any decrement or reload in that cycle.
- Writing CTRL never changes COUNT.
- LOAD=0 with AUTO=1: expires on every tick. PEND stays set and OVR sets from the second expiry on.
- Simultaneous W1C of PEND and a new expiry in the same cycle: set wins, so PEND=1 and OVR is unchanged by the clear. The same rule applies to OVR.
- INTR = PEND & IE, from registers only, so glitch-free. It stays high until software clears PEND or IE. This suits the MCU sampling INTR gated by MSTATUS.MIE.
- Reset values: CTRL=0, LOAD=0, COUNT=0, PEND=0, OVR=0, PRESCALE=0, prescale counter=0. IOBUS_IN=0 unless the address hits, INTR=0.
- RST mid-count: everything returns to reset values on that edge. The same-cycle write is discarded.
- No state machine beyond the EN/expiry control: IDLE (EN=0), RUN (EN=1), and a return to IDLE on one-shot expiry.

Optional Feature:
- Macro: IOBUS_TIMER_PRESCALE_EN.
- With it:
  - 16-bit PRESCALE register at 0x10 and a 16-bit prescale counter PS that runs while EN=1.
  - Tick=1 when PS==PRESCALE; PS then returns to 0, otherwise it increments.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE, or EN going 0->1, clears PS.
- Without it: no PRESCALE or PS flops, tick=EN, offset 0x10 unmapped (reads 0).

Decomposition:
- Shared package iobus_pkg holds:
  - offset localparams TMR_CTRL_OFS, TMR_LOAD_OFS, TMR_COUNT_OFS, TMR_STATUS_OFS, TMR_PRESCALE_OFS;
  - CTRL bit indices;
  - a packed struct type for CTRL/STATUS, reused by later IO responders.
- One natural sub-module: iobus_timer_presc (prescaler/tick generator), only instantiated under the macro. Otherwise tick=EN inline.

Test Plan:
- Reset, then read all offsets -> IOBUS_IN=0 for each; INTR=0. Read BASE_ADDR+0x20 -> 0.
- One-shot: write LOAD=3, CTRL=0b101. Then:
  - COUNT reads 2,1,0 on consecutive cycles.
  - Next cycle PEND=1, INTR=1, EN=0, COUNT holds 0.
  - W1C STATUS=1 -> INTR=0 the next cycle.
- Auto-reload: LOAD=1, CTRL=0b111, no clears -> PEND set after 2 cycles, OVR set after 4. COUNT sequence 1,0,1,0…
- Race: write STATUS=0x1 in the exact expiry cycle -> PEND stays 1. Write LOAD=9 in the expiry cycle -> COUNT=9 next cycle, PEND=1.
- Mid-run RST while COUNT=5 and PEND=1 -> the next cycle all registers read 0 and INTR=0.
- With macro: PRESCALE=2, LOAD=2, EN=1 -> COUNT decrements every 3rd cycle; expiry 9 cycles after enable.
